// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch PC generator; redirects that arrive under stall are held and replayed.
// Define PC_GEN_BTB_EN to build the direct-mapped BTB with 2-bit counters (default: no BTB).
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     STALL_W   = 5,
    parameter int unsigned     BTB_IDX_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_signal,
    input  logic               jump_flag,
    input  logic [XLEN-1:0]    branch_to,
    input  logic               upd_valid,
    input  logic [XLEN-1:0]    upd_pc,
    input  logic [XLEN-1:0]    upd_target,
    input  logic               upd_taken,
    output logic [XLEN-1:0]    pc,
    output logic               pred_taken,
    output logic [XLEN-1:0]    pred_target,
    output logic               redir_pending
);

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            pend_q;
    logic            pend_d;
    logic [XLEN-1:0] pend_tgt_q;
    logic [XLEN-1:0] pend_tgt_d;
    logic            pred_taken_s;
    logic [XLEN-1:0] pred_target_s;

`ifdef PC_GEN_BTB_EN
    localparam int unsigned TAG_W   = XLEN - BTB_IDX_W - 2;
    localparam int unsigned ENTRIES = 1 << BTB_IDX_W;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    logic [BTB_IDX_W-1:0] lk_idx_s;
    logic [TAG_W-1:0]     lk_tag_s;
    logic [BTB_IDX_W-1:0] up_idx_s;
    logic [TAG_W-1:0]     up_tag_s;
    logic                 up_hit_s;
    logic                 unused_s;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    assign lk_idx_s      = pc_q[BTB_IDX_W+1:2];
    assign lk_tag_s      = pc_q[XLEN-1:BTB_IDX_W+2];
    assign up_idx_s      = upd_pc[BTB_IDX_W+1:2];
    assign up_tag_s      = upd_pc[XLEN-1:BTB_IDX_W+2];
    assign up_hit_s      = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
    assign pred_taken_s  = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s) && ctr_q[lk_idx_s][1];
    assign pred_target_s = tgt_q[lk_idx_s];
    assign unused_s      = ^{stall_signal[STALL_W-1:1], upd_pc[1:0]};

    // BTB training; lookups this cycle still see the pre-update contents
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            if (up_hit_s) begin
                ctr_q[up_idx_s] <= ctr_next(ctr_q[up_idx_s], upd_taken);
                if (upd_taken) begin
                    tgt_q[up_idx_s] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[up_idx_s] <= 1'b1;
                tag_q[up_idx_s]   <= up_tag_s;
                tgt_q[up_idx_s]   <= upd_target;
                ctr_q[up_idx_s]   <= 2'b10;
            end
        end
    end
`else
    logic unused_s;

    assign pred_taken_s  = 1'b0;
    assign pred_target_s = '0;
    assign unused_s      = ^{stall_signal[STALL_W-1:1], upd_valid, upd_pc, upd_target, upd_taken};
`endif

    // Next-PC selection: stall > live jump > held redirect > prediction > sequential
    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        if (stall_signal[0]) begin
            if (jump_flag) begin
                pend_d     = 1'b1;
                pend_tgt_d = branch_to;
            end else begin
                pend_d     = pend_q;
            end
        end else if (jump_flag) begin
            pc_d   = branch_to;
            pend_d = 1'b0;
        end else if (pend_q) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
        end else if (pred_taken_s) begin
            pc_d = pred_target_s;
        end else begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC and held-redirect state
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc            = pc_q;
    assign redir_pending = pend_q;
    assign pred_taken    = pred_taken_s;
    assign pred_target   = pred_target_s;

endmodule
